// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer sharing one external 8-bit ALU (IDLE -> EXEC -> RESP).
// Optional ALU_ARB_STATS_EN adds per-requester completed-operation counters ops0_cnt/ops1_cnt.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [5:0]       req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [5:0]       req1_ctl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      ops0_cnt,
  output logic [15:0]      ops1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [5:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d;
  logic             win, grant, hs0, hs1;

  // win = 0 selects req0, 1 selects req1; ptr_q names the requester favoured on a tie
  always_comb begin
    win = ~req0_valid;
    if (req0_valid && req1_valid) win = FIXED_PRIO ? 1'b0 : ptr_q;
  end

  // rst gating keeps ready low while reset is held even though the state is already IDLE
  assign grant      = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = grant && !win;
  assign req1_ready = grant &&  win;

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign hs0        = rsp0_valid && rsp0_ready;
  assign hs1        = rsp1_valid && rsp1_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    ctl_d   = ctl_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    case (state_q)
      IDLE: if (grant) begin
        ax_d    = win ? req1_x   : req0_x;
        ay_d    = win ? req1_y   : req0_y;
        ctl_d   = win ? req1_ctl : req0_ctl;
        owner_d = win;
        ptr_d   = ~win;
        state_d = EXEC;
      end
      EXEC: begin
        out_d   = alu_out;
        zr_d    = alu_zr;
        ng_d    = alu_ng;
        state_d = RESP;
      end
      RESP: if (hs0 || hs1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      ax_q    <= '0;
      ay_q    <= '0;
      ctl_q   <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      ctl_q   <= ctl_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  assign alu_x   = ax_q;
  assign alu_y   = ay_q;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctl_q;
  assign rsp_out = out_q;
  assign rsp_zr  = zr_q;
  assign rsp_ng  = ng_q;
  assign busy    = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // only completed response handshakes count; natural 16-bit wrap
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (hs0) cnt0_d = cnt0_q + 16'd1;
    if (hs1) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign ops0_cnt = cnt0_q;
  assign ops1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed-priority; each drives a behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       r0v [2], r1v [2], s0r [2], s1r [2];
  logic [7:0] x0 [2], y0 [2], x1 [2], y1 [2];
  logic [5:0] ct0 [2], ct1 [2];
  wire        r0r [2], r1r [2], s0v [2], s1v [2], zr [2], ng [2], busy [2], azr [2], ang [2];
  wire  [7:0] out [2], ax [2], ay [2], aout [2];
  wire  [5:0] actl [2];
`ifdef ALU_ARB_STATS_EN
  wire [15:0] cnt0 [2], cnt1 [2];
`endif

  function automatic logic [9:0] alu_m(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
    logic [7:0] a, b, o;
    a = c[5] ? 8'h00 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 8'h00 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return {o[7], (o == 8'h00), o};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {ang[g], azr[g], aout[g]} = alu_m(ax[g], ay[g], actl[g]);
    alu_arbiter #(.FIXED_PRIO(g[0]), .WIDTH(8)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_x(x0[g]), .req0_y(y0[g]), .req0_ctl(ct0[g]),
      .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_x(x1[g]), .req1_y(y1[g]), .req1_ctl(ct1[g]),
      .rsp0_valid(s0v[g]), .rsp0_ready(s0r[g]), .rsp1_valid(s1v[g]), .rsp1_ready(s1r[g]),
      .rsp_out(out[g]), .rsp_zr(zr[g]), .rsp_ng(ng[g]),
      .alu_x(ax[g]), .alu_y(ay[g]),
      .alu_zx(actl[g][5]), .alu_nx(actl[g][4]), .alu_zy(actl[g][3]),
      .alu_ny(actl[g][2]), .alu_f(actl[g][1]), .alu_no(actl[g][0]),
      .alu_out(aout[g]), .alu_zr(azr[g]), .alu_ng(ang[g]),
      .busy(busy[g])
`ifdef ALU_ARB_STATS_EN
      , .ops0_cnt(cnt0[g]), .ops1_cnt(cnt1[g])
`endif
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard index = dut*2 + requester; entries are {ng, zr, out}
  logic [9:0] sbq [4][$];
  int  ecnt [4];
  int  acc_c [2], last_gc [2];
  logic last_g [2], have_g [2], prev_rv [2];
  logic bb = 1'b0, fixm = 1'b0;
  int  ngr1 = 0;

  task automatic accept(input int d, input int r, input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
    sbq[d*2+r].push_back(alu_m(x, y, c));
    if (bb && d == 0 && have_g[0]) begin
      chk("rr_alternate", r, {31'b0, !last_g[0]});
      chk("rr_gap", cyc - last_gc[0], 3);
    end
    if (fixm && d == 1) begin
      chk("fix_winner", r, 0);
      ngr1++;
    end
    have_g[d]  = 1'b1;
    last_g[d]  = r[0];
    last_gc[d] = cyc;
    acc_c[d]   = cyc;
  endtask

  task automatic retire(input int d, input int r);
    logic [9:0] e;
    if (sbq[d*2+r].size() == 0) chk("sb_unexpected_rsp", 1, 0);
    else begin
      e = sbq[d*2+r].pop_front();
      chk("rsp_out", out[d], e[7:0]);
      chk("rsp_zr", zr[d], e[8]);
      chk("rsp_ng", ng[d], e[9]);
      ecnt[d*2+r]++;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 2; r++) begin
          sbq[d*2+r].delete();
          ecnt[d*2+r] = 0;
        end
        prev_rv[d] = 1'b0;
      end else begin
        chk("ready_exclusive", r0r[d] && r1r[d], 0);
        if (busy[d]) chk("ready_while_busy", r0r[d] || r1r[d], 0);
        chk("rsp_exclusive", s0v[d] && s1v[d], 0);
        if (fixm && d == 1 && r0v[1]) chk("fix_r1_ready", r1r[1], 0);
        if (r0v[d] && r0r[d]) accept(d, 0, x0[d], y0[d], ct0[d]);
        if (r1v[d] && r1r[d]) accept(d, 1, x1[d], y1[d], ct1[d]);
        if ((s0v[d] || s1v[d]) && !prev_rv[d]) chk("latency", cyc - acc_c[d], 2);
        prev_rv[d] = s0v[d] || s1v[d];
        if (s0v[d] && s0r[d]) retire(d, 0);
        if (s1v[d] && s1r[d]) retire(d, 1);
      end
    end
  end

  task automatic send(input int d, input int r, input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
    logic got;
    @(posedge clk); #1;
    if (r == 0) begin x0[d] = x; y0[d] = y; ct0[d] = c; r0v[d] = 1'b1; end
    else        begin x1[d] = x; y1[d] = y; ct1[d] = c; r1v[d] = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? r0r[d] : r1r[d];
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    r0v[d] = 1'b0;
    r1v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = !busy[d];
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  logic [7:0] hold_out, hold_ax;
  logic       got;

  initial begin
    for (int d = 0; d < 2; d++) begin
      r0v[d] = 0; r1v[d] = 0; s0r[d] = 1; s1r[d] = 1;
      x0[d] = 0; y0[d] = 0; x1[d] = 0; y1[d] = 0; ct0[d] = 0; ct1[d] = 0;
      have_g[d] = 0; last_g[d] = 0; last_gc[d] = 0; acc_c[d] = 0; prev_rv[d] = 0;
    end
    r0v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req0_ready", r0r[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_rsp_out", out[0], 0);
    chk("rst_alu_x", ax[0], 0);
    chk("rst_alu_ctl", actl[0], 0);
    chk("rst_rsp0_valid", s0v[0], 0);
    r0v[0] = 1'b0;
    rst = 1'b0;

    // x + y
    send(0, 0, 8'h05, 8'h03, 6'b000010);
    wait_idle(0);
    chk("add_out", out[0], 8'h08);
    chk("add_zr", zr[0], 0);
    chk("add_ng", ng[0], 0);

    // x - y, then constant zero
    send(0, 1, 8'h05, 8'h03, 6'b010011);
    wait_idle(0);
    chk("sub_out", out[0], 8'h02);
    send(0, 1, 8'h05, 8'h03, 6'b101010);
    wait_idle(0);
    chk("zero_out", out[0], 8'h00);
    chk("zero_zr", zr[0], 1);

    // round-robin under constant contention; operands change every cycle
    @(posedge clk); #1;
    have_g[0] = 1'b0;
    bb = 1'b1;
    ct0[0] = 6'b111010;
    ct1[0] = 6'b000010;
    r0v[0] = 1'b1;
    r1v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x0[0] = 8'($urandom); y0[0] = 8'($urandom);
      x1[0] = 8'($urandom); y1[0] = 8'($urandom);
      @(posedge clk); #1;
    end
    r0v[0] = 1'b0;
    r1v[0] = 1'b0;
    wait_idle(0);
    bb = 1'b0;
    chk("minus1_out", out[0] & {8{last_g[0] == 1'b0}}, {8{last_g[0] == 1'b0}});

    // fixed priority: req0 always wins
    @(posedge clk); #1;
    fixm = 1'b1;
    r0v[1] = 1'b1;
    r1v[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x0[1] = 8'($urandom); y0[1] = 8'($urandom); ct0[1] = 6'($urandom);
      x1[1] = 8'($urandom); y1[1] = 8'($urandom); ct1[1] = 6'($urandom);
      @(posedge clk); #1;
    end
    r0v[1] = 1'b0;
    r1v[1] = 1'b0;
    wait_idle(1);
    fixm = 1'b0;
    chk("fix_grant_count", ngr1 >= 4, 1);
    send(1, 1, 8'h80, 8'h00, 6'b000010);
    wait_idle(1);
    chk("fix_r1_alone_ng", ng[1], 1);

    // response back-pressure: result and ALU lines hold, other channel ignored
    s0r[0] = 1'b0;
    send(0, 0, 8'h7F, 8'h01, 6'b000010);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = s0v[0];
    end
    if (!got) chk("rsp_timeout", 0, 1);
    hold_out = out[0];
    hold_ax  = ax[0];
    chk("hold_first_out", hold_out, 8'h80);
    @(posedge clk); #1;
    x1[0] = 8'h01; y1[0] = 8'h01; ct1[0] = 6'b000010; r1v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s1r[0] = i[0];
      @(negedge clk);
      chk("hold_valid", s0v[0], 1);
      chk("hold_out", out[0], hold_out);
      chk("hold_alu_x", ax[0], hold_ax);
      chk("hold_busy", busy[0], 1);
      chk("hold_r1_ready", r1r[0], 0);
      chk("hold_rsp1_valid", s1v[0], 0);
      @(posedge clk); #1;
    end
    s1r[0] = 1'b1;
    s0r[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = r1r[0];
    end
    if (!got) chk("r1_after_hold_timeout", 0, 1);
    @(posedge clk); #1;
    r1v[0] = 1'b0;
    wait_idle(0);
    chk("after_hold_out", out[0], 8'h02);

    // reset while in EXEC discards the operation
    @(posedge clk); #1;
    x0[0] = 8'h11; y0[0] = 8'h22; ct0[0] = 6'b000010; r0v[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = r0r[0];
    end
    if (!got) chk("rst_accept_timeout", 0, 1);
    @(posedge clk); #2;
    chk("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_ready", r0r[0], 0);
    chk("mid_rst_alu_x", ax[0], 0);
    chk("mid_rst_alu_ctl", actl[0], 0);
    chk("mid_rst_out", out[0], 0);
    r0v[0] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", s0v[0] || s1v[0], 0);
    end
`ifdef ALU_ARB_STATS_EN
    chk("post_rst_ops0", cnt0[0], 0);
`endif
    send(0, 0, 8'h0F, 8'hF0, 6'b000000);
    wait_idle(0);
    chk("and_out", out[0], 8'h00);
    chk("and_zr", zr[0], 1);

    for (int i = 0; i < 4; i++) chk("sb_drained", sbq[i].size(), 0);
`ifdef ALU_ARB_STATS_EN
    chk("ops0_cnt_d0", cnt0[0], ecnt[0]);
    chk("ops1_cnt_d0", cnt1[0], ecnt[1]);
    chk("ops0_cnt_d1", cnt0[1], ecnt[2]);
    chk("ops1_cnt_d1", cnt1[1], ecnt[3]);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-port arbiter and sequencer that shares a single 8-bit ALU instance between two requesters. Each requester issues one operation through a valid/ready handshake: operands plus the six ALU control bits. The block registers the winning operation onto the ALU control/operand lines, captures out/zr/ng one cycle later, and returns the result to the owning requester through its own valid/ready response channel. It sits between the ALU and its clients (e.g. instruction sequencer and address generator).

Parameters:
FIXED_PRIO, 0, 0 = round-robin between req0/req1; 1 = req0 always wins when both valid
WIDTH, 8, operand/result width; must match the ALU (only 8 supported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_x  input  WIDTH  requester 0 x operand
req0_y  input  WIDTH  requester 0 y operand
req0_ctl  input  6  requester 0 controls {zx,nx,zy,ny,f,no}
req1_valid, req1_ready, req1_x, req1_y, req1_ctl  same as requester 0, for requester 1
rsp0_valid  output  1  result ready for requester 0
rsp0_ready  input  1  requester 0 consumes result
rsp1_valid  output  1  result ready for requester 1
rsp1_ready  input  1  requester 1 consumes result
rsp_out  output  WIDTH  result data (shared by both response channels)
rsp_zr  output  1  result zero flag
rsp_ng  output  1  result negative flag
alu_x, alu_y  output  WIDTH  operands to ALU
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1  ALU controls
alu_out  input  WIDTH  ALU result
alu_zr, alu_ng  input  1  ALU flags
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0 (req0 favoured next); alu_* registers 0.
- States: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, pick winner:
  - FIXED_PRIO=1 -> req0 when valid.
  - Otherwise, when both are valid, winner is the requester favoured by the pointer; a single valid requester always wins.
  - Assert winner's reqN_ready combinationally in that cycle (only in IDLE, only to the winner).
  - On the edge: latch x/y/ctl into alu_* registers, record owner, flip the pointer to favour the loser -> EXEC.
- EXEC (exactly 1 cycle): capture alu_out/alu_zr/alu_ng into rsp_out/rsp_zr/rsp_ng -> RESP.
- RESP: assert rspN_valid for the owner only; hold rsp_* and alu_* stable until rspN_ready. When rspN_valid && rspN_ready, return to IDLE and deassert rspN_valid the next cycle.
- Latency: request acceptance edge to rspN_valid high = 2 cycles. Back-to-back throughput = one op per 3 cycles when rspN_ready is held high.
- reqN_ready is never asserted outside IDLE. A requester holding valid while busy waits; its operands may change without effect until it is accepted.
- rspN_ready while the owner's rspN_valid is low is ignored. The non-owner's rspN_ready is always ignored.
- Simultaneous rspN handshake and new reqN_valid: the handshake takes effect and arbitration happens in the following IDLE cycle (no bypass).
- Reset mid-operation: returns to IDLE immediately and discards the pending result; no rsp_valid is issued for it.
- The arbiter does not interpret results; flags are passed through exactly as the ALU computes them.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds outputs ops0_cnt[15:0] and ops1_cnt[15:0]. Each increments on a completed rspN handshake, wraps FFFF->0000, and resets to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- req0 x=8'h05, y=8'h03, ctl=6'b000010 (x+y) -> rsp0_valid 2 cycles after accept; rsp_out=8'h08, zr=0, ng=0.
- req1 x=8'h05, y=8'h03, ctl=6'b010011 (x-y) -> rsp1_valid with out=8'h02; then ctl=6'b101010 (zero) -> out=8'h00, zr=1.
- Both valid every cycle, FIXED_PRIO=0, rsp ready held -> grants alternate 0,1,0,1, one grant per 3 cycles; ctl=6'b111010 -> out=8'hFF, ng=1.
- FIXED_PRIO=1, both valid -> req0 wins every time; req1_ready never asserted while req0_valid is high.
- rsp0_ready held low for 10 cycles in RESP -> rsp0_valid and rsp_out stay stable, busy=1, no req accepted; rsp1_ready pulses are ignored.
- rst asserted during EXEC -> all outputs 0 asynchronously, no response; with ALU_ARB_STATS_EN, ops0_cnt=0 and counts only completed handshakes afterwards.
